// File: rtl/apf_csr_pkg.sv
// apf_csr_pkg: shared constants, FSM state types and the DFH field layout
// for the APF CSR responder.
package apf_csr_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_e;

    // DFH word layout, LSB first: feature id, revision, next offset, EOL, reserved, type
    localparam int DFH_ID_W   = 12;
    localparam int DFH_REV_W  = 4;
    localparam int DFH_NEXT_W = 24;
    localparam int DFH_EOL_W  = 1;
    localparam int DFH_RSVD_W = 19;
    localparam int DFH_TYPE_W = 4;
    localparam int DFH_W      = DFH_ID_W + DFH_REV_W + DFH_NEXT_W + DFH_EOL_W
                              + DFH_RSVD_W + DFH_TYPE_W;

    // Merge new bytes into an old word wherever the strobe bit is set
    function automatic logic [63:0] apply_strb(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apf_csr_wr_ctrl.sv
// apf_csr_wr_ctrl: write-side handshake engine. Accepts AW and W in either
// order, buffers whichever half arrives first, emits a one-cycle commit
// strobe when both halves are present and then holds the B response until
// the host takes it. The register file decides the response code.
module apf_csr_wr_ctrl
    import apf_csr_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [63:0]       wdata,
    input  logic [7:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              commit,
    output logic [ADDR_W-1:0] commit_addr,
    output logic [63:0]       commit_data,
    output logic [7:0]        commit_strb,
    input  logic [1:0]        commit_resp
);

    wr_state_e         state;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       data_q;
    logic [7:0]        strb_q;
    logic              aw_hs;
    logic              w_hs;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    // Commit when the missing half lands; pick buffered vs live halves
    always_comb begin
        commit      = 1'b0;
        commit_addr = awaddr;
        commit_data = wdata;
        commit_strb = wstrb;
        case (state)
            WR_IDLE:    commit = aw_hs & w_hs;
            WR_HAVE_AW: begin
                commit      = w_hs;
                commit_addr = addr_q;
            end
            WR_HAVE_W:  begin
                commit      = aw_hs;
                commit_data = data_q;
                commit_strb = strb_q;
            end
            default:    commit = 1'b0;
        endcase
    end

    // Write FSM with registered readies and B channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WR_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else if (commit) begin
            state   <= WR_RESP;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= commit_resp;
        end else begin
            case (state)
                WR_IDLE: begin
                    if (aw_hs) begin
                        addr_q  <= awaddr;
                        state   <= WR_HAVE_AW;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                    end else if (w_hs) begin
                        data_q  <= wdata;
                        strb_q  <= wstrb;
                        state   <= WR_HAVE_W;
                        awready <= 1'b1;
                        wready  <= 1'b0;
                    end else begin
                        // also raises the readies on the first edge out of reset
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        state   <= WR_IDLE;
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                WR_HAVE_AW, WR_HAVE_W: ;
                default: state <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/apf_csr_responder.sv
// apf_csr_responder: AXI4-Lite CSR endpoint for one APF function port.
// idx 0 is the read-only DFH, idx 1 the scratchpad, idx 2..NUM_REGS-1 RW.
// Optional feature macro: APF_CSR_ERRLOG_EN adds a read-only error log at
// idx NUM_REGS (SLVERR count in [63:32], first failing address in the low
// bits, cleared by any write).
module apf_csr_responder
    import apf_csr_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter int          DATA_W    = 64,
    parameter int          NUM_REGS  = 8,
    parameter logic [63:0] DFH_VALUE = 64'h3000_0000_1000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [7:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready
);

    if (DATA_W != 64) begin : g_bad_data_w
        $error("apf_csr_responder: DATA_W must be 64");
    end
    if (NUM_REGS < 2) begin : g_bad_num_regs
        $error("apf_csr_responder: NUM_REGS must be at least 2");
    end
    if (DFH_W != 64) begin : g_bad_dfh
        $error("apf_csr_responder: DFH field widths must total 64");
    end

    logic                   commit;
    logic [ADDR_W-1:0]      commit_addr;
    logic [63:0]            commit_data;
    logic [7:0]             commit_strb;
    logic [1:0]             commit_resp;
    logic [31:0]            wr_sel;
    logic [31:0]            rd_sel;
    logic                   wr_rw;
    logic                   wr_log;
    logic [NUM_REGS-1:1][63:0] regs;
    logic [63:0]            rd_val;
    logic [1:0]             rd_resp;
    logic [63:0]            log_val;
    logic                   ar_hs;
    rd_state_e              rd_state;
    logic                   unused_bits;

    // Protection bits and sub-word address bits carry no meaning here
    assign unused_bits = ^{awprot, arprot, araddr[2:0], commit_addr[2:0]};

    apf_csr_wr_ctrl #(.ADDR_W(ADDR_W)) u_wr_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .awaddr      (awaddr),
        .awvalid     (awvalid),
        .awready     (awready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wvalid      (wvalid),
        .wready      (wready),
        .bresp       (bresp),
        .bvalid      (bvalid),
        .bready      (bready),
        .commit      (commit),
        .commit_addr (commit_addr),
        .commit_data (commit_data),
        .commit_strb (commit_strb),
        .commit_resp (commit_resp)
    );

    assign wr_sel = 32'(commit_addr[ADDR_W-1:3]);
    assign rd_sel = 32'(araddr[ADDR_W-1:3]);
    assign wr_rw  = (wr_sel >= 32'd1) && (wr_sel < 32'(NUM_REGS));
`ifdef APF_CSR_ERRLOG_EN
    assign wr_log = (wr_sel == 32'(NUM_REGS));
`else
    assign wr_log = 1'b0;
`endif
    assign commit_resp = (wr_rw || wr_log) ? RESP_OKAY : RESP_SLVERR;
    assign ar_hs       = arvalid & arready;

    // RW register file: byte-strobed update on the commit cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (commit) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_sel == 32'(i)) regs[i] <= apply_strb(regs[i], commit_data, commit_strb);
            end
        end
    end

    // Read mux; sees pre-commit register values within the commit cycle
    always_comb begin
        rd_val  = '0;
        rd_resp = RESP_SLVERR;
        if (rd_sel == 32'd0) begin
            rd_val  = DFH_VALUE;
            rd_resp = RESP_OKAY;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rd_sel == 32'(i)) begin
                rd_val  = regs[i];
                rd_resp = RESP_OKAY;
            end
        end
`ifdef APF_CSR_ERRLOG_EN
        if (rd_sel == 32'(NUM_REGS)) begin
            rd_val  = log_val;
            rd_resp = RESP_OKAY;
        end
`endif
    end

    // Read FSM: capture on AR handshake, hold until R handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rdata    <= rd_val;
                        rresp    <= rd_resp;
                        rvalid   <= 1'b1;
                        arready  <= 1'b0;
                        rd_state <= RD_RESP;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (rready) begin
                        rvalid   <= 1'b0;
                        arready  <= 1'b1;
                        rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

`ifdef APF_CSR_ERRLOG_EN
    logic [31:0]       err_cnt;
    logic [ADDR_W-1:0] err_addr;
    logic              err_seen;
    logic              wr_err;
    logic              rd_err;
    logic [32:0]       err_sum;

    assign wr_err  = commit && !(wr_rw || wr_log);
    assign rd_err  = ar_hs && (rd_resp == RESP_SLVERR);
    assign err_sum = {1'b0, err_cnt} + 33'(wr_err) + 33'(rd_err);
    assign log_val = {err_cnt, 32'(err_addr)};

    // Error log: saturating SLVERR count plus first failing address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt  <= '0;
            err_addr <= '0;
            err_seen <= 1'b0;
        end else if (commit && wr_log) begin
            // a read error landing in the clearing cycle still counts
            err_cnt  <= 32'(rd_err);
            err_seen <= rd_err;
            err_addr <= rd_err ? araddr : '0;
        end else if (wr_err || rd_err) begin
            err_cnt <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
            if (!err_seen) begin
                err_seen <= 1'b1;
                err_addr <= wr_err ? commit_addr : araddr;
            end
        end
    end
`else
    assign log_val = '0;
`endif

endmodule
